// File: rtl/decode_stage_if.sv
// decode_stage_if
// Groups the fetch-side and execute-side handshake signals of the RV32I(+M) decode stage.
//   fetch side   : in_valid, in_ready, instr, pc
//   execute side : out_valid, out_ready, out_pc, decoded control bundle, illegal_cnt
// The master modport is the environment (fetch and execute). The slave modport is the decode stage.
interface decode_stage_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic             rd_wren;
    logic             mem_wren;
    logic             is_load;
    logic             branch;
    logic             jump;
    logic             op_a_sel;
    logic             op_b_sel;
    logic [31:0]      imm;
    logic [4:0]       alu_op;
    logic [2:0]       br_op;
    logic [3:0]       ld_op;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, instr, pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd_addr,
               rd_wren, mem_wren, is_load, branch, jump, op_a_sel, op_b_sel,
               imm, alu_op, br_op, ld_op, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, instr, pc, out_ready,
        output in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd_addr,
               rd_wren, mem_wren, is_load, branch, jump, op_a_sel, op_b_sel,
               imm, alu_op, br_op, ld_op, illegal, illegal_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
// Registered RV32I(+M) decode stage between fetch and execute.
// Decodes one instruction per cycle into a registered control bundle. It also provides an optional
// M-extension decode, illegal-instruction detection, an optional 1-entry skid buffer, a synchronous
// flush, and a saturating count of illegal bundles handed to execute.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   flush  kills every instruction held in the stage at the next edge
//   bus    decode_stage_if.slave: fetch handshake in, decoded bundle out
module decode_stage #(
    parameter int unsigned EN_M  = 0,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wren;
        logic        mem_wren;
        logic        is_load;
        logic        branch;
        logic        jump;
        logic        op_a_sel;
        logic        op_b_sel;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic [2:0]  br_op;
        logic [3:0]  ld_op;
        logic        illegal;
    } bundle_t;

    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_base = 5'd0;
            3'b001:  alu_base = 5'd7;
            3'b010:  alu_base = 5'd2;
            3'b011:  alu_base = 5'd3;
            3'b100:  alu_base = 5'd4;
            3'b101:  alu_base = 5'd8;
            3'b110:  alu_base = 5'd5;
            default: alu_base = 5'd6;
        endcase
    endfunction

    function automatic logic [3:0] mem_width(input logic [2:0] f3);
        case (f3)
            3'b000:  mem_width = 4'b1001;
            3'b001:  mem_width = 4'b1011;
            3'b010:  mem_width = 4'b1111;
            3'b100:  mem_width = 4'b0001;
            3'b101:  mem_width = 4'b0011;
            default: mem_width = 4'b0000;
        endcase
    endfunction

    logic [6:0]  w_opc;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;
    logic        w_bad;
    bundle_t     w_dec;

    assign w_opc   = bus.instr[6:0];
    assign w_f3    = bus.instr[14:12];
    assign w_f7    = bus.instr[31:25];
    assign w_imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign w_imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign w_imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7], bus.instr[30:25],
                      bus.instr[11:8], 1'b0};
    assign w_imm_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12], bus.instr[20],
                      bus.instr[30:21], 1'b0};
    assign w_imm_u = {bus.instr[31:12], 12'b0};

    always_comb begin
        w_dec    = '0;
        w_bad    = 1'b0;
        w_dec.pc = bus.pc;
        case (w_opc)
            OPC_LUI: begin
                w_dec.rd       = bus.instr[11:7];
                w_dec.rd_wren  = 1'b1;
                w_dec.op_b_sel = 1'b1;
                w_dec.imm      = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec.rd       = bus.instr[11:7];
                w_dec.rd_wren  = 1'b1;
                w_dec.op_a_sel = 1'b1;
                w_dec.op_b_sel = 1'b1;
                w_dec.imm      = w_imm_u;
            end
            OPC_JAL: begin
                w_dec.rd       = bus.instr[11:7];
                w_dec.rd_wren  = 1'b1;
                w_dec.jump     = 1'b1;
                w_dec.op_a_sel = 1'b1;
                w_dec.op_b_sel = 1'b1;
                w_dec.imm      = w_imm_j;
                w_dec.br_op    = 3'd6;
            end
            OPC_JALR: begin
                w_dec.rd       = bus.instr[11:7];
                w_dec.rs1      = bus.instr[19:15];
                w_dec.rd_wren  = 1'b1;
                w_dec.jump     = 1'b1;
                w_dec.op_a_sel = 1'b1;
                w_dec.op_b_sel = 1'b1;
                w_dec.imm      = w_imm_i;
                w_dec.br_op    = 3'd7;
                w_bad          = (w_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_dec.rs1      = bus.instr[19:15];
                w_dec.rs2      = bus.instr[24:20];
                w_dec.branch   = 1'b1;
                w_dec.op_a_sel = 1'b1;
                w_dec.op_b_sel = 1'b1;
                w_dec.imm      = w_imm_b;
                // funct3 100..111 map onto br_op 2..5; 000/001 map directly.
                w_dec.br_op    = w_f3[2] ? (w_f3 - 3'd2) : w_f3;
                w_bad          = (w_f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                w_dec.rd       = bus.instr[11:7];
                w_dec.rs1      = bus.instr[19:15];
                w_dec.rd_wren  = 1'b1;
                w_dec.is_load  = 1'b1;
                w_dec.op_b_sel = 1'b1;
                w_dec.imm      = w_imm_i;
                w_dec.ld_op    = mem_width(w_f3);
                w_bad          = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                w_dec.rs1      = bus.instr[19:15];
                w_dec.rs2      = bus.instr[24:20];
                w_dec.mem_wren = 1'b1;
                w_dec.op_b_sel = 1'b1;
                w_dec.imm      = w_imm_s;
                w_dec.ld_op    = mem_width(w_f3);
                w_bad          = (w_f3 > 3'b010);
            end
            OPC_OPIMM: begin
                w_dec.rd       = bus.instr[11:7];
                w_dec.rs1      = bus.instr[19:15];
                w_dec.rd_wren  = 1'b1;
                w_dec.op_b_sel = 1'b1;
                w_dec.imm      = w_imm_i;
                w_dec.alu_op   = alu_base(w_f3);
                // The shift-immediate funct7 lives in the upper immediate bits.
                if (w_f3 == 3'b001) begin
                    w_bad = (w_f7 != 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    if (w_f7 == 7'b0100000) begin
                        w_dec.alu_op = 5'd9;
                    end else if (w_f7 != 7'b0000000) begin
                        w_bad = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                w_dec.rd      = bus.instr[11:7];
                w_dec.rs1     = bus.instr[19:15];
                w_dec.rs2     = bus.instr[24:20];
                w_dec.rd_wren = 1'b1;
                w_dec.alu_op  = alu_base(w_f3);
                if (w_f7 == 7'b0000001) begin
                    if (EN_M != 0) begin
                        w_dec.alu_op = 5'd10 + {2'b00, w_f3};
                    end else begin
                        w_bad = 1'b1;
                    end
                end else if (w_f7 == 7'b0100000) begin
                    if (w_f3 == 3'b000) begin
                        w_dec.alu_op = 5'd1;
                    end else if (w_f3 == 3'b101) begin
                        w_dec.alu_op = 5'd9;
                    end else begin
                        w_bad = 1'b1;
                    end
                end else if (w_f7 != 7'b0000000) begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b1;
        endcase
        // Any opcode whose low bits are not 11 misses every case item above.
        if (w_bad) begin
            w_dec.illegal  = 1'b1;
            w_dec.rd_wren  = 1'b0;
            w_dec.mem_wren = 1'b0;
            w_dec.is_load  = 1'b0;
            w_dec.branch   = 1'b0;
            w_dec.jump     = 1'b0;
        end
    end

    bundle_t           r_out;
    bundle_t           r_skid;
    logic              r_out_valid;
    logic              r_skid_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_out_free;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_out_free = ~r_out_valid | bus.out_ready;
    assign w_in_ready = (SKID != 0) ? ~r_skid_valid : w_out_free;
    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    // The skid entry is only filled while the output register is held. Without SKID, in_fire implies
    // that the output register is free, so the skid path is never taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_out_fire && r_out.illegal && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= w_in_fire;
                    if (w_in_fire) begin
                        r_skid <= w_dec;
                    end
                end else begin
                    r_out_valid <= w_in_fire;
                    if (w_in_fire) begin
                        r_out <= w_dec;
                    end
                end
            end else if (w_in_fire) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_out.pc;
    assign bus.rs1_addr    = r_out.rs1;
    assign bus.rs2_addr    = r_out.rs2;
    assign bus.rd_addr     = r_out.rd;
    assign bus.rd_wren     = r_out.rd_wren;
    assign bus.mem_wren    = r_out.mem_wren;
    assign bus.is_load     = r_out.is_load;
    assign bus.branch      = r_out.branch;
    assign bus.jump        = r_out.jump;
    assign bus.op_a_sel    = r_out.op_a_sel;
    assign bus.op_b_sel    = r_out.op_b_sel;
    assign bus.imm         = r_out.imm;
    assign bus.alu_op      = r_out.alu_op;
    assign bus.br_op       = r_out.br_op;
    assign bus.ld_op       = r_out.ld_op;
    assign bus.illegal     = r_out.illegal;
    assign bus.illegal_cnt = r_cnt;
endmodule
